// File: rtl/sensor_pkg.sv
// Shared types and default timing constants for the humidity sensor filter.
package sensor_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 4;
  localparam int unsigned ALARM_CYCLES_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WATCH = 2'b01,
    ALARM = 2'b10,
    MUTED = 2'b11
  } alarm_state_t;

endpackage

// File: rtl/sensor_filter_if.sv
// Sensor/alarm bus between the environment (master) and the filter (slave).
interface sensor_filter_if;

  logic [1:0] sensor_raw;
  logic       alarm_ack;
  logic [1:0] sensores;
  logic       changed;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output sensor_raw,
    output alarm_ack,
    input  sensores,
    input  changed,
    input  alarm,
    input  state
  );

  modport slave (
    input  sensor_raw,
    input  alarm_ack,
    output sensores,
    output changed,
    output alarm,
    output state
  );

endinterface

// File: rtl/sensor_filter_debounce2.sv
// Two-flop synchronizer followed by a saturating stability counter; a candidate
// value is accepted once it has been seen on STABLE_CYCLES consecutive edges.
module debounce2 #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] value,
  output logic       changed
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      cand    <= 2'b00;
      cnt     <= '0;
      value   <= 2'b00;
      changed <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      changed <= 1'b0;
      if (sync2 != cand) begin
        // New synchronized value: this edge is the first one it has been seen.
        cand <= sync2;
        cnt  <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
        if ((cnt == CNT_MAX - CW'(1)) && (cand != value)) begin
          value   <= cand;
          changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sensor_filter.sv
// Debounced two-area humidity sensor with a persistence alarm and operator mute.
module sensor_filter
  import sensor_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned ALARM_CYCLES  = ALARM_CYCLES_DEF
) (
  input  logic           clk_2,
  input  logic           reset,
  sensor_filter_if.slave bus
);

  localparam int unsigned AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0] ACNT_MAX = AW'(ALARM_CYCLES);

  logic [1:0]    value;
  logic          value_changed;
  alarm_state_t  st;
  logic [AW-1:0] acnt;
  logic          alarm_q;

  debounce2 #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk     (clk_2),
    .reset   (reset),
    .raw     (bus.sensor_raw),
    .value   (value),
    .changed (value_changed)
  );

  // Alarm FSM; sensores == 00 always wins over alarm_ack.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      st      <= IDLE;
      acnt    <= '0;
      alarm_q <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (value != 2'b00) begin
            st   <= WATCH;
            acnt <= '0;
          end
          alarm_q <= 1'b0;
        end
        WATCH: begin
          if (value == 2'b00) begin
            st      <= IDLE;
            alarm_q <= 1'b0;
          end else if (acnt == ACNT_MAX - AW'(1)) begin
            st      <= ALARM;
            acnt    <= ACNT_MAX;
            alarm_q <= 1'b1;
          end else begin
            acnt    <= acnt + AW'(1);
            alarm_q <= 1'b0;
          end
        end
        ALARM: begin
          if (value == 2'b00) begin
            st      <= IDLE;
            alarm_q <= 1'b0;
          end else if (bus.alarm_ack) begin
            st      <= MUTED;
            alarm_q <= 1'b0;
          end else begin
            alarm_q <= 1'b1;
          end
        end
        MUTED: begin
          if (value == 2'b00) begin
            st <= IDLE;
          end
          alarm_q <= 1'b0;
        end
        default: begin
          st      <= IDLE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sensores = value;
  assign bus.changed  = value_changed;
  assign bus.alarm    = alarm_q;
  assign bus.state    = st;

endmodule

// File: tb/tb_sensor_filter.sv
// Directed scoreboard bench for sensor_filter at default parameters (4/8).
module tb_sensor_filter;
  import sensor_pkg::*;

  typedef struct {
    int         cyc;
    string      tag;
    logic [1:0] s;
    logic       ch;
    logic       al;
    logic [1:0] st;
  } exp_t;

  logic clk_2;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;
  int   base;
  exp_t q[$];

  sensor_filter_if bus ();

  sensor_filter dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s.%s cyc=%0d got=%0h exp=%0h", tag, fld, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [1:0] s, input logic ch,
                      input logic al, input logic [1:0] st);
    exp_t e;
    e.cyc = c; e.tag = tag; e.s = s; e.ch = ch; e.al = al; e.st = st;
    q.push_back(e);
  endtask

  // Advance one edge, sample 1ns later, retire every expectation due by now.
  task automatic tick();
    exp_t e;
    @(posedge clk_2);
    #1;
    cyc++;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk(e.tag, "sensores", 8'(bus.sensores), 8'(e.s));
      chk(e.tag, "changed",  8'(bus.changed),  8'(e.ch));
      chk(e.tag, "alarm",    8'(bus.alarm),    8'(e.al));
      chk(e.tag, "state",    8'(bus.state),    8'(e.st));
    end
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    push(cyc + 1, tag, 2'b00, 1'b0, 1'b0, IDLE);
    tick();
    reset = 1'b0;
  endtask

  // Expected trace for 00 -> v held from before edge 1 of a fresh start.
  task automatic push_step(input string tag, input int b, input logic [1:0] v, input int last);
    for (int k = 1; k <= last; k++)
      push(b + k, tag, (k >= 6) ? v : 2'b00, k == 6, k >= 15,
           (k >= 15) ? ALARM : ((k >= 7) ? WATCH : IDLE));
  endtask

  initial begin
    cyc = 0; tests = 0; fails = 0;
    reset = 1'b1;
    bus.sensor_raw = 2'b00;
    bus.alarm_ack  = 1'b0;
    push(1, "reset", 2'b00, 1'b0, 1'b0, IDLE);
    push(2, "reset", 2'b00, 1'b0, 1'b0, IDLE);
    tick(); tick();

    // Step 00->01: accepted at edge 6, alarm at edge 15.
    reset = 1'b0;
    bus.sensor_raw = 2'b01;
    base = cyc;
    push_step("step", base, 2'b01, 16);
    repeat (16) tick();

    // Acknowledge in ALARM, then dry reading clears back to IDLE.
    bus.alarm_ack = 1'b1;
    push(base + 17, "ack", 2'b01, 1'b0, 1'b0, MUTED);
    tick();
    bus.alarm_ack  = 1'b0;
    bus.sensor_raw = 2'b00;
    for (int k = 18; k <= 25; k++)
      push(base + k, "unmute", (k >= 23) ? 2'b00 : 2'b01, k == 23, 1'b0,
           (k >= 24) ? IDLE : MUTED);
    repeat (8) tick();

    // Short glitch must never reach sensores.
    reset_pulse("rst_glitch");
    base = cyc;
    for (int k = 1; k <= 12; k++)
      push(base + k, "glitch", 2'b00, 1'b0, 1'b0, IDLE);
    bus.sensor_raw = 2'b10;
    repeat (3) tick();
    bus.sensor_raw = 2'b00;
    repeat (9) tick();

    // Nonzero code change mid-WATCH, ack ignored in WATCH, alarm still at 15.
    reset_pulse("rst_code");
    base = cyc;
    bus.sensor_raw = 2'b01;
    for (int k = 1; k <= 16; k++)
      push(base + k, "code", (k < 6) ? 2'b00 : ((k < 13) ? 2'b01 : 2'b11),
           (k == 6) || (k == 13), k >= 15,
           (k >= 15) ? ALARM : ((k >= 7) ? WATCH : IDLE));
    repeat (7) tick();
    bus.sensor_raw = 2'b11;
    tick();
    bus.alarm_ack = 1'b1;
    tick(); tick();
    bus.alarm_ack = 1'b0;
    repeat (6) tick();

    // Ack on the same edge sensores returns to 00: IDLE wins.
    bus.sensor_raw = 2'b00;
    for (int k = 17; k <= 22; k++)
      push(base + k, "simul", (k == 22) ? 2'b00 : 2'b11, k == 22, 1'b1, ALARM);
    push(base + 23, "simul", 2'b00, 1'b0, 1'b0, IDLE);
    push(base + 24, "simul", 2'b00, 1'b0, 1'b0, IDLE);
    repeat (6) tick();
    bus.alarm_ack = 1'b1;
    tick();
    bus.alarm_ack = 1'b0;
    tick();

    // Reset at WATCH count 5, then re-acceptance from scratch.
    reset_pulse("rst_pre");
    base = cyc;
    bus.sensor_raw = 2'b01;
    push_step("pre", base, 2'b01, 12);
    repeat (12) tick();
    reset_pulse("rst_watch");
    base = cyc;
    push_step("reacc", base, 2'b01, 16);
    repeat (16) tick();

    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain left=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
